// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide unit owning the HI/LO pair.
// Define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU; DIV/DIVU stay iterative.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNTW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d, bz_q, bz_d, negp_q, negp_d, negr_q, negr_d, done_q, done_d;
    logic               sgn, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
    logic [WIDTH:0]     add_sum, sub_diff;
    logic [2*WIDTH-1:0] prod_fix;
    assign sgn = ~op[0];
    assign sa = sgn & a[WIDTH-1];
    assign sb = sgn & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;
    // Multiply: add multiplicand into upper half when LSB set, then shift right.
    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Divide: trial-subtract divisor from the left-shifted partial remainder.
    assign sub_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    assign prod_fix = negp_q ? -acc_q : acc_q;
    assign quo_fix = negp_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
    assign ext_a = {{WIDTH{sa | (sgn & a[WIDTH-1])}}, a};
    assign ext_b = {{WIDTH{sb | (sgn & b[WIDTH-1])}}, b};
    assign fast_prod = ext_a * ext_b;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        opb_d = opb_q;
        a_d = a_q;
        hi_d = hi_q;
        lo_d = lo_q;
        is_div_d = is_div_q;
        bz_d = bz_q;
        negp_d = negp_q;
        negr_d = negr_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (start && !flush) begin
                if (op == 3'd4) hi_d = a;
                else if (op == 3'd5) lo_d = a;
`ifdef MULDIV_FAST_MUL_EN
                else if (op[2:1] == 2'b00) begin
                    {hi_d, lo_d} = fast_prod;
                    done_d = 1'b1;
                end
`endif
                else if (!op[2]) begin
                    state_d = CALC;
                    cnt_d = '0;
                    is_div_d = op[1];
                    acc_d = {{WIDTH{1'b0}}, mag_a};
                    opb_d = mag_b;
                    a_d = a;
                    bz_d = (b == '0);
                    negp_d = sa ^ sb;
                    negr_d = sa;
                end
            end
            CALC: begin
                acc_d = !is_div_q ? {add_sum, acc_q[WIDTH-1:1]} :
                        sub_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} :
                        {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(WIDTH - 1)) state_d = FIX;
            end
            default: begin
                state_d = IDLE;
                done_d = 1'b1;
                {hi_d, lo_d} = !is_div_q ? prod_fix : bz_q ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
            end
        endcase
        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            hi_d = hi_q;
            lo_d = lo_q;
            done_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            opb_q <= '0;
            a_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            is_div_q <= 1'b0;
            bz_q <= 1'b0;
            negp_q <= 1'b0;
            negr_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opb_q <= opb_d;
            a_q <= a_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            is_div_q <= is_div_d;
            bz_q <= bz_d;
            negp_q <= negp_d;
            negr_q <= negr_d;
            done_q <= done_d;
        end
    end
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule
